// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped, tagged branch history table of 2-bit saturating counters,
//   plus 32-bit branch / mispredict statistics counters.
//
//   Lookup (fetch/decode, combinational):
//     guess_pc, guess_is_branch -> br_taken
//   Update (execute, applied on the next rising edge):
//     check_pc, check_is_branch, check_pred, br_suc, br_mispred
//   Statistics (registered):
//     stat_branches, stat_mispreds
//   clk : all state changes on the rising edge
//   rst : synchronous, active-low
//
//   STAT_BITS sets the internal width of the statistics counters. The ports
//   are always 32 bits; a narrower build zero-extends, which makes the wrap
//   behaviour cheap to exercise.
module branch_predictor #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = PC_WIDTH - INDEX_BITS - 2,
  parameter int STAT_BITS  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] guess_pc,
  input  logic                guess_is_branch,
  output logic                br_taken,
  input  logic [PC_WIDTH-1:0] check_pc,
  input  logic                check_is_branch,
  input  logic                check_pred,
  input  logic                br_suc,
  input  logic                br_mispred,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispreds
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]   valid;
  logic [TAG_BITS-1:0]  tags [ENTRIES];
  logic [1:0]           cnt  [ENTRIES];
  logic [STAT_BITS-1:0] stat_br;
  logic [STAT_BITS-1:0] stat_mis;

  logic [INDEX_BITS-1:0] g_idx, c_idx;
  logic [TAG_BITS-1:0]   g_tag, c_tag;
  logic                  g_hit, c_hit;
  logic                  upd, actual;
  logic [1:0]            cur_cnt, nxt_cnt;

  // Instructions are word aligned; the low PC bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{guess_pc[1:0], check_pc[1:0]};

  assign g_idx = guess_pc[INDEX_BITS+1:2];
  assign g_tag = guess_pc[PC_WIDTH-1:INDEX_BITS+2];
  assign c_idx = check_pc[INDEX_BITS+1:2];
  assign c_tag = check_pc[PC_WIDTH-1:INDEX_BITS+2];

  // ---------------------------------------------------------------- lookup
  // Reads the registered table only, so a same-cycle update is not visible.
  assign g_hit    = valid[g_idx] && (tags[g_idx] == g_tag);
  assign br_taken = rst && guess_is_branch && g_hit && cnt[g_idx][1];

  // ---------------------------------------------------------------- update
  // br_mispred wins when both resolution flags are raised, so the real
  // outcome is always the issued guess flipped by br_mispred.
  assign upd     = check_is_branch && (br_suc || br_mispred);
  assign actual  = check_pred ^ br_mispred;
  assign c_hit   = valid[c_idx] && (tags[c_idx] == c_tag);
  assign cur_cnt = cnt[c_idx];

  always_comb begin
    nxt_cnt = cur_cnt;
    if (!c_hit)
      // Allocation (cold or alias) starts in the weak state of the outcome.
      nxt_cnt = actual ? 2'b10 : 2'b01;
    else if (actual && cur_cnt != 2'b11)
      nxt_cnt = cur_cnt + 2'b01;
    else if (!actual && cur_cnt != 2'b00)
      nxt_cnt = cur_cnt - 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid    <= '0;
      stat_br  <= '0;
      stat_mis <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt[i] <= 2'b01;
    end else if (upd) begin
      valid[c_idx] <= 1'b1;
      cnt[c_idx]   <= nxt_cnt;
      stat_br      <= stat_br + 1'b1;
      if (br_mispred) stat_mis <= stat_mis + 1'b1;
    end
  end

  // Tags are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (rst && upd) tags[c_idx] <= c_tag;
  end

  assign stat_branches = 32'(stat_br);
  assign stat_mispreds = 32'(stat_mis);

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Full-width instance
  logic        rst = 1'b0;
  logic [31:0] guess_pc = '0;
  logic        guess_is_branch = 1'b0;
  logic        br_taken;
  logic [31:0] check_pc = '0;
  logic        check_is_branch = 1'b0;
  logic        check_pred = 1'b0;
  logic        br_suc = 1'b0;
  logic        br_mispred = 1'b0;
  logic [31:0] stat_branches, stat_mispreds;

  // Narrow-statistics instance used to reach the wrap point quickly
  logic        rst2 = 1'b0;
  logic [31:0] guess_pc2 = '0;
  logic        guess_is_branch2 = 1'b0;
  logic        br_taken2;
  logic [31:0] check_pc2 = 32'h0000_0040;
  logic        check_is_branch2 = 1'b0;
  logic        check_pred2 = 1'b0;
  logic        br_suc2 = 1'b0;
  logic        br_mispred2 = 1'b0;
  logic [31:0] stat_branches2, stat_mispreds2;

  branch_predictor dut (
    .clk(clk), .rst(rst),
    .guess_pc(guess_pc), .guess_is_branch(guess_is_branch), .br_taken(br_taken),
    .check_pc(check_pc), .check_is_branch(check_is_branch), .check_pred(check_pred),
    .br_suc(br_suc), .br_mispred(br_mispred),
    .stat_branches(stat_branches), .stat_mispreds(stat_mispreds)
  );

  branch_predictor #(.STAT_BITS(4)) dut2 (
    .clk(clk), .rst(rst2),
    .guess_pc(guess_pc2), .guess_is_branch(guess_is_branch2), .br_taken(br_taken2),
    .check_pc(check_pc2), .check_is_branch(check_is_branch2), .check_pred(check_pred2),
    .br_suc(br_suc2), .br_mispred(br_mispred2),
    .stat_branches(stat_branches2), .stat_mispreds(stat_mispreds2)
  );

  typedef struct {
    string       name;
    bit          which;   // 0: dut, 1: dut2
    bit          chk_st;  // compare statistics too
    logic        taken;
    logic [31:0] br;
    logic [31:0] mis;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A = 32'h1000_0010;  // index 4
  localparam logic [31:0] B = 32'h1000_0090;  // index 4, different tag

  // One cycle on the full-width DUT: inputs applied just after the edge, the
  // expectation describes what the DUT shows before the following edge.
  task automatic drv(input string nm, input logic r, input logic [31:0] gpc,
                     input logic gbr, input logic [31:0] cpc, input logic cbr,
                     input logic cpred, input logic suc, input logic mis,
                     input logic et, input logic [31:0] eb, input logic [31:0] em,
                     input bit cs);
    exp_t e;
    @(posedge clk); #1;
    rst = r; guess_pc = gpc; guess_is_branch = gbr;
    check_pc = cpc; check_is_branch = cbr; check_pred = cpred;
    br_suc = suc; br_mispred = mis;
    e.name = nm; e.which = 1'b0; e.chk_st = cs; e.taken = et; e.br = eb; e.mis = em;
    sb.push_back(e);
  endtask

  task automatic drv2(input string nm, input logic r, input logic cbr,
                      input logic [31:0] eb, input logic [31:0] em, input bit cs);
    exp_t e;
    @(posedge clk); #1;
    rst2 = r; check_is_branch2 = cbr; br_mispred2 = cbr;
    e.name = nm; e.which = 1'b1; e.chk_st = cs; e.taken = 1'b0; e.br = eb; e.mis = em;
    sb.push_back(e);
  endtask

  // Monitor: every cycle that has an expectation queued is checked at the
  // falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic        a_t;
      logic [31:0] a_b, a_m;
      e   = sb.pop_front();
      a_t = e.which ? br_taken2      : br_taken;
      a_b = e.which ? stat_branches2 : stat_branches;
      a_m = e.which ? stat_mispreds2 : stat_mispreds;
      checks++;
      if (a_t !== e.taken) begin
        errors++;
        $display("FAIL %s br_taken: got %b expected %b", e.name, a_t, e.taken);
      end
      if (e.chk_st) begin
        checks++;
        if (a_b !== e.br) begin
          errors++;
          $display("FAIL %s stat_branches: got %h expected %h", e.name, a_b, e.br);
        end
        checks++;
        if (a_m !== e.mis) begin
          errors++;
          $display("FAIL %s stat_mispreds: got %h expected %h", e.name, a_m, e.mis);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   name         rst gpc gbr cpc cbr pred suc mis  exp_t  br  mis  chk_stats
    drv("rst0",       0,  A,  1,  A,  0,  0,   0,  0,   0,     0,  0,   0);
    drv("rst1",       0,  A,  1,  A,  0,  0,   0,  0,   0,     0,  0,   1);
    // Cold miss; mispredicted not-taken allocates counter 10
    drv("cold_miss",  1,  A,  1,  A,  1,  0,   0,  1,   0,     0,  0,   1);
    // Four taken hits: 10 -> 11 -> 11 -> 11 -> 11
    drv("alloc_T",    1,  A,  1,  A,  1,  1,   1,  0,   1,     1,  1,   1);
    drv("tk2",        1,  A,  1,  A,  1,  1,   1,  0,   1,     2,  1,   1);
    drv("tk3",        1,  A,  1,  A,  1,  1,   1,  0,   1,     3,  1,   1);
    drv("tk4",        1,  A,  1,  A,  1,  1,   1,  0,   1,     4,  1,   1);
    // Two not-taken mispredicts: 11 -> 10 -> 01
    drv("sat11",      1,  A,  1,  A,  1,  1,   0,  1,   1,     5,  1,   1);
    drv("dec10",      1,  A,  1,  A,  1,  1,   0,  1,   1,     6,  2,   1);
    // Back up to 11: 01 -> 10 (mispredict), 10 -> 11 (correct)
    drv("dec01",      1,  A,  1,  A,  1,  0,   0,  1,   0,     7,  3,   1);
    drv("inc10",      1,  A,  1,  A,  1,  1,   1,  0,   1,     8,  4,   1);
    // Alias: B not-taken (pred 1, mispredict) retags index 4 with counter 01
    drv("alias_upd",  1,  A,  1,  B,  1,  1,   0,  1,   1,     9,  4,   1);
    // A now misses; B hits at 01 and goes to 10
    drv("alias_miss", 1,  A,  1,  B,  1,  0,   0,  1,   0,    10,  5,   1);
    // B predicts taken; A re-allocated not-taken (counter 01)
    drv("B_hit",      1,  B,  1,  A,  1,  0,   1,  0,   1,    11,  6,   1);
    // Same-cycle lookup and update of A: 01 -> 10, lookup sees old value
    drv("same_cyc",   1,  A,  1,  A,  1,  0,   0,  1,   0,    12,  6,   1);
    // check_is_branch=0 with mispredict must not touch anything
    drv("next_cyc",   1,  A,  1,  A,  0,  1,   0,  1,   1,    13,  7,   1);
    drv("no_branch",  1,  A,  1,  A,  0,  0,   0,  0,   1,    13,  7,   1);
    // Non-branch lookup -> 0; both flags set counts as mispredict (10 -> 11)
    drv("gbr0_both",  1,  A,  0,  A,  1,  0,   1,  1,   0,    13,  7,   1);
    // Reset with a pending update (would hit at 11): br_taken forced low now
    drv("rst_pend",   0,  A,  1,  A,  1,  1,   1,  0,   0,    14,  8,   1);
    // After the reset edge: stats cleared, entry invalid, update lost
    drv("post_rst",   1,  A,  1,  A,  0,  0,   0,  0,   0,     0,  0,   1);
    drv("post_rst2",  1,  A,  1,  A,  0,  0,   0,  0,   0,     0,  0,   1);

    // Statistics wrap on the 4-bit build: 15 -> 0
    drv2("w_rst0", 0, 0, 0, 0, 0);
    drv2("w_rst1", 0, 0, 0, 0, 1);
    for (int k = 0; k < 16; k++) begin
      drv2("w_cnt", 1, 1, 32'(k), 32'(k), (k == 0 || k == 7 || k == 15));
    end
    drv2("w_wrap", 1, 0, 0, 0, 1);
    drv2("w_hold", 1, 0, 0, 0, 1);

    begin
      int n = 0;
      while (sb.size() > 0 && n < 20) begin
        @(posedge clk);
        n++;
      end
      if (sb.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
